// File: rtl/rawhits_parity_gen.sv
// -----------------------------------------------------------------------------
// rawhits_parity_gen
//
// Shadow parity store for the raw hits RAM. Each write to the raw hits RAM
// stores one even-parity bit per layer in an internal 2**RAM_ADRB x MXLY
// parity RAM. Each read recomputes parity from the main RAM read data and
// flags a per-layer mismatch two clocks after the read address was presented.
// After every reset the parity RAM is cleared by a sweep (INIT) before
// checking is enabled. A one-shot injection port flips selected parity bits
// on one write so the checker can be exercised in-system.
//
// Ports
//   clock          40MHz main clock (only clock)
//   global_reset_n asynchronous active-low reset
//   fifo_wen       write strobe for the raw hits RAM
//   fifo_wadr      write address
//   fifo_wdata     write data, layer n at [n*MXDS +: MXDS]
//   fifo_ren       read address valid
//   fifo_radr      read address
//   fifo_rdata     main RAM read data, valid 1 clock after fifo_radr
//   inject_req     parity error injection request
//   inject_ly      layers to corrupt on injection
//   inject_ack     one-clock pulse when an injection has been consumed
//   init_done      parity RAM fully initialised, checking enabled
//   parity_err     per-layer read parity error, one clock per bad read
// -----------------------------------------------------------------------------
module rawhits_parity_gen #(
    parameter int MXLY     = 6,
    parameter int MXDS     = 8,
    parameter int RAM_ADRB = 11
) (
    input  logic                 clock,
    input  logic                 global_reset_n,
    input  logic                 fifo_wen,
    input  logic [RAM_ADRB-1:0]  fifo_wadr,
    input  logic [MXLY*MXDS-1:0] fifo_wdata,
    input  logic                 fifo_ren,
    input  logic [RAM_ADRB-1:0]  fifo_radr,
    input  logic [MXLY*MXDS-1:0] fifo_rdata,
    input  logic                 inject_req,
    input  logic [MXLY-1:0]      inject_ly,
    output logic                 inject_ack,
    output logic                 init_done,
    output logic [MXLY-1:0]      parity_err
);

    localparam int unsigned RAM_DEPTH = 1 << RAM_ADRB;
    localparam logic [RAM_ADRB-1:0] ADR_ONE  = RAM_ADRB'(1);
    localparam logic [RAM_ADRB-1:0] ADR_LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Control state
    state_t              state_q, state_d;
    logic [RAM_ADRB-1:0] init_adr_q, init_adr_d;
    logic                init_done_q, init_done_d;
    logic                inject_ack_q, inject_ack_d;
    logic                inject_done_q, inject_done_d;

    // Read pipeline
    logic                ren_q;
    logic [MXLY-1:0]     rd_par_q;
    logic [MXLY-1:0]     parity_err_q, parity_err_d;

    // Parity RAM port
    logic [MXLY-1:0]     par_ram [0:RAM_DEPTH-1];
    logic                ram_we;
    logic [RAM_ADRB-1:0] ram_wadr;
    logic [MXLY-1:0]     ram_wdata;

    // Datapath
    logic [MXLY-1:0]     wr_par;
    logic [MXLY-1:0]     calc_par;
    logic [MXLY-1:0]     inj_mask;

    // -------------------------------------------------------------------------
    // Per-layer parity of write data and of read-back data
    // -------------------------------------------------------------------------
    always_comb begin
        wr_par   = '0;
        calc_par = '0;
        for (int unsigned n = 0; n < MXLY; n++) begin
            wr_par[n]   = ^fifo_wdata[n*MXDS +: MXDS];
            calc_par[n] = ^fifo_rdata[n*MXDS +: MXDS];
        end
    end

    // -------------------------------------------------------------------------
    // Injection: armed only in RUN and only until one write consumes it.
    // inject_done stays set while the request is held, so a held request
    // corrupts a single write; dropping the request re-arms it.
    // -------------------------------------------------------------------------
    always_comb begin
        inj_mask      = '0;
        if (inject_req && (state_q == RUN) && !inject_done_q) begin
            inj_mask = inject_ly;
        end
        inject_ack_d  = fifo_wen && (inj_mask != '0);
        inject_done_d = inject_req && (inject_done_q || inject_ack_d);
    end

    // -------------------------------------------------------------------------
    // FSM next state and parity RAM write port.
    // External writes always win the RAM port; the init sweep stalls.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        init_adr_d = init_adr_q;
        ram_we     = fifo_wen;
        ram_wadr   = fifo_wadr;
        ram_wdata  = wr_par ^ inj_mask;

        unique case (state_q)
            IDLE: begin
                state_d = INIT;
            end
            INIT: begin
                if (!fifo_wen) begin
                    ram_we     = 1'b1;
                    ram_wadr   = init_adr_q;
                    ram_wdata  = '0;
                    init_adr_d = init_adr_q + ADR_ONE;
                    if (init_adr_q == ADR_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        init_done_d = (state_d == RUN);
    end

    // -------------------------------------------------------------------------
    // Read check: stored parity and ren arrive one clock after the address,
    // together with the main RAM data; the error is registered one clock later.
    // -------------------------------------------------------------------------
    always_comb begin
        parity_err_d = (calc_par ^ rd_par_q) & {MXLY{ren_q && init_done_q}};
    end

    // -------------------------------------------------------------------------
    // Control and pipeline registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q       <= IDLE;
            init_adr_q    <= '0;
            init_done_q   <= 1'b0;
            inject_ack_q  <= 1'b0;
            inject_done_q <= 1'b0;
            ren_q         <= 1'b0;
            parity_err_q  <= '0;
        end else begin
            state_q       <= state_d;
            init_adr_q    <= init_adr_d;
            init_done_q   <= init_done_d;
            inject_ack_q  <= inject_ack_d;
            inject_done_q <= inject_done_d;
            ren_q         <= fifo_ren;
            parity_err_q  <= parity_err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Parity RAM: no reset, cleared by the INIT sweep. Read and write share
    // an edge, so a same-address read returns the old contents.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (ram_we) begin
            par_ram[ram_wadr] <= ram_wdata;
        end
        if (fifo_ren) begin
            rd_par_q <= par_ram[fifo_radr];
        end
    end

    assign inject_ack = inject_ack_q;
    assign init_done  = init_done_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_rawhits_parity_gen.sv
module tb_rawhits_parity_gen;

    localparam int MXLY  = 6;
    localparam int MXDS  = 8;
    localparam int ADRB  = 11;
    localparam int DEPTH = 1 << ADRB;
    localparam int DW    = MXLY * MXDS;

    logic            clock = 1'b0;
    logic            global_reset_n = 1'b0;
    logic            fifo_wen = 1'b0;
    logic [ADRB-1:0] fifo_wadr = '0;
    logic [DW-1:0]   fifo_wdata = '0;
    logic            fifo_ren = 1'b0;
    logic [ADRB-1:0] fifo_radr = '0;
    logic [DW-1:0]   fifo_rdata = '0;
    logic            inject_req = 1'b0;
    logic [MXLY-1:0] inject_ly = '0;
    logic            inject_ack;
    logic            init_done;
    logic [MXLY-1:0] parity_err;

    rawhits_parity_gen #(.MXLY(MXLY), .MXDS(MXDS), .RAM_ADRB(ADRB)) dut (
        .clock          (clock),
        .global_reset_n (global_reset_n),
        .fifo_wen       (fifo_wen),
        .fifo_wadr      (fifo_wadr),
        .fifo_wdata     (fifo_wdata),
        .fifo_ren       (fifo_ren),
        .fifo_radr      (fifo_radr),
        .fifo_rdata     (fifo_rdata),
        .inject_req     (inject_req),
        .inject_ly      (inject_ly),
        .inject_ack     (inject_ack),
        .init_done      (init_done),
        .parity_err     (parity_err)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural reference: an array of stored parity, a count of addresses
    // cleared since reset, and the result of the previous cycle's read.
    logic [MXLY-1:0] m_par [DEPTH];
    bit              m_idle;
    int              m_ptr;
    bit              m_prev_ren;
    logic [MXLY-1:0] m_prev_st;
    bit              m_consumed;

    function automatic logic [MXLY-1:0] lpar(input logic [DW-1:0] d);
        logic [MXLY-1:0] p;
        logic [MXDS-1:0] b;
        for (int n = 0; n < MXLY; n++) begin
            b    = d[n*MXDS +: MXDS];
            p[n] = ($countones(b) % 2) == 1;
        end
        return p;
    endfunction

    task automatic model_reset();
        m_idle     = 1'b1;
        m_ptr      = 0;
        m_prev_ren = 1'b0;
        m_prev_st  = '0;
        m_consumed = 1'b0;
    endtask

    // One clock: drive inputs, advance model, check outputs 1ns after the edge.
    // rdata belongs to the read issued on the previous call.
    task automatic cycle(input logic wen, input logic [ADRB-1:0] wadr, input logic [DW-1:0] wdata,
                         input logic ren, input logic [ADRB-1:0] radr, input logic [DW-1:0] rdata,
                         input logic ireq, input logic [MXLY-1:0] ily);
        bit              run;
        logic [MXLY-1:0] exp_err, mask, st;
        bit              exp_ack;
        fifo_wen   = wen;  fifo_wadr = wadr; fifo_wdata = wdata;
        fifo_ren   = ren;  fifo_radr = radr; fifo_rdata = rdata;
        inject_req = ireq; inject_ly = ily;

        run     = !m_idle && (m_ptr == DEPTH);
        exp_err = (m_prev_ren && run) ? (lpar(rdata) ^ m_prev_st) : '0;
        st      = m_par[radr];
        mask    = (ireq && run && !m_consumed) ? ily : '0;
        exp_ack = wen && (mask != '0);
        m_consumed = ireq && (m_consumed || exp_ack);
        if (wen) m_par[wadr] = lpar(wdata) ^ mask;
        if (m_idle) m_idle = 1'b0;
        else if (!run && !wen) begin
            m_par[m_ptr] = '0;
            m_ptr++;
        end
        m_prev_ren = ren;
        m_prev_st  = st;

        @(posedge clock);
        #1;
        check_eq("parity_err", 32'(parity_err), 32'(exp_err));
        check_eq("inject_ack", 32'(inject_ack), 32'(exp_ack));
        check_eq("init_done", 32'(init_done), 32'(!m_idle && m_ptr == DEPTH));
    endtask

    task automatic idle_cycle();
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Release reset between edges and count clocks until init_done.
    task automatic release_and_wait(input int pre_idle, input int n_wr, input int expect_clks,
                                    output logic [DW-1:0] wd [64]);
        int n;
        global_reset_n = 1'b1;
        model_reset();
        n = 0;
        for (int i = 0; i < pre_idle; i++) begin idle_cycle(); n++; end
        for (int i = 0; i < n_wr; i++) begin
            wd[i] = {$urandom, $urandom};
            cycle(1'b1, ADRB'(i), wd[i], 1'b0, '0, '0, 1'b0, '0);
            n++;
        end
        while (!init_done && n < 5000) begin idle_cycle(); n++; end
        check_eq("init_latency", 32'(n), 32'(expect_clks));
    endtask

    logic [DW-1:0] wd [64];
    logic [DW-1:0] d;
    logic [DW-1:0] prev_rd;

    initial begin
        model_reset();
        #23;
        check_eq("rst_init_done", 32'(init_done), 32'd0);
        check_eq("rst_parity_err", 32'(parity_err), 32'd0);
        check_eq("rst_inject_ack", 32'(inject_ack), 32'd0);
        @(posedge clock); #1;

        // Reset release with no traffic
        release_and_wait(0, 0, DEPTH + 1, wd);

        // Good data reads back clean
        d = {MXLY{8'h01}};
        cycle(1'b1, 11'd5, d, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b1, 11'd5, '0, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, d, 1'b0, '0);
        check_eq("good_read_adr5", 32'(parity_err), 32'd0);

        // Injection on layer 2, request held across a second write
        d = {$urandom, $urandom};
        cycle(1'b1, 11'd7, d, 1'b0, '0, '0, 1'b1, 6'b000100);
        check_eq("inject_ack_pulse", 32'(inject_ack), 32'd1);
        cycle(1'b1, 11'd8, d, 1'b1, 11'd7, '0, 1'b1, 6'b000100);
        check_eq("inject_ack_once", 32'(inject_ack), 32'd0);
        cycle(1'b0, '0, '0, 1'b1, 11'd8, d, 1'b1, 6'b000100);
        check_eq("inject_err_adr7", 32'(parity_err), 32'b000100);
        cycle(1'b0, '0, '0, 1'b0, '0, d, 1'b0, '0);
        check_eq("held_req_adr8_clean", 32'(parity_err), 32'd0);

        // Single-layer data error lasts one clock
        d = '0; d[3*MXDS +: MXDS] = 8'h03;
        cycle(1'b1, 11'd9, d, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b1, 11'd9, '0, 1'b0, '0);
        d[3*MXDS +: MXDS] = 8'h07;
        cycle(1'b0, '0, '0, 1'b0, '0, d, 1'b0, '0);
        check_eq("layer3_err", 32'(parity_err), 32'b001000);
        idle_cycle();
        check_eq("layer3_err_not_latched", 32'(parity_err), 32'd0);

        // Same-address read and write: read returns old parity
        d = '0; d[0 +: MXDS] = 8'h01;
        cycle(1'b1, 11'd12, '0, 1'b0, '0, '0, 1'b0, '0);
        cycle(1'b1, 11'd12, d, 1'b1, 11'd12, '0, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, d, 1'b0, '0);
        check_eq("read_first_old", 32'(parity_err), 32'b000001);

        // Randomized traffic on a small address window
        prev_rd = '0;
        for (int i = 0; i < 600; i++) begin
            logic ir;
            ir = ($urandom_range(3, 0) == 0);
            cycle($urandom_range(1, 0) == 1, ADRB'($urandom_range(31, 0)), {$urandom, $urandom},
                  $urandom_range(1, 0) == 1, ADRB'($urandom_range(31, 0)), prev_rd,
                  ir, MXLY'($urandom));
            prev_rd = ($urandom_range(1, 0) == 1) ? {$urandom, $urandom} : '0;
        end

        // Reset mid-RUN with a read in flight
        cycle(1'b0, '0, '0, 1'b1, 11'd200, '0, 1'b0, '0);
        cycle(1'b0, '0, '0, 1'b1, 11'd200, 48'h1, 1'b0, '0);
        check_eq("pre_reset_err", 32'(parity_err), 32'b000001);
        #3 global_reset_n = 1'b0;
        #1;
        check_eq("async_rst_parity_err", 32'(parity_err), 32'd0);
        check_eq("async_rst_init_done", 32'(init_done), 32'd0);
        fifo_ren = 1'b0; fifo_rdata = 48'h1;
        @(posedge clock); #1;
        check_eq("rst_hold_parity_err", 32'(parity_err), 32'd0);
        release_and_wait(0, 0, DEPTH + 1, wd);

        // Writes during INIT stall the sweep; their parity survives
        #3 global_reset_n = 1'b0;
        @(posedge clock); #1;
        release_and_wait(100, 50, DEPTH + 1 + 50, wd);
        for (int i = 0; i < 50; i++) begin
            cycle(1'b0, '0, '0, 1'b1, ADRB'(i), (i == 0) ? '0 : wd[i-1], 1'b0, '0);
            if (i > 0) check_eq("init_wr_readback", 32'(parity_err), 32'd0);
        end
        cycle(1'b0, '0, '0, 1'b1, 11'd3, wd[49], 1'b0, '0);
        check_eq("init_wr_readback_last", 32'(parity_err), 32'd0);
        d = wd[3]; d[0] = ~d[0];
        cycle(1'b0, '0, '0, 1'b0, '0, d, 1'b0, '0);
        check_eq("init_wr_flip_detect", 32'(parity_err), 32'b000001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule

// File: doc/rawhits_parity_gen.md
RAWHITS_PARITY_GEN -- requirements
Module: rawhits_parity_gen

Interface
REQ-001 The module SHALL have parameter MXLY, default 6, number of layers per CFEB.
REQ-002 The module SHALL have parameter MXDS, default 8, data bits per layer per RAM word.
REQ-003 The module SHALL have parameter RAM_ADRB, default 11, raw hits RAM address width (2048 words).
REQ-004 The module SHALL have port clock, input, 1, 40MHz TMB main clock; it SHALL be the only clock.
REQ-005 The module SHALL have port global_reset_n, input, 1, global reset; reset is asynchronous and active-low.
REQ-006 The module SHALL have port fifo_wen, input, 1, 1=write raw hits RAM this cycle.
REQ-007 The module SHALL have port fifo_wadr, input, RAM_ADRB, write address.
REQ-008 The module SHALL have port fifo_wdata, input, MXLY*MXDS, write data; layer n occupies bits [n*MXDS +: MXDS].
REQ-009 The module SHALL have port fifo_ren, input, 1, 1=read address valid this cycle.
REQ-010 The module SHALL have port fifo_radr, input, RAM_ADRB, read address.
REQ-011 The module SHALL have port fifo_rdata, input, MXLY*MXDS, main RAM read data, valid 1 clock after fifo_radr.
REQ-012 The module SHALL have port inject_req, input, 1, parity error injection request.
REQ-013 The module SHALL have port inject_ly, input, MXLY, layers to corrupt on injection.
REQ-014 The module SHALL have port inject_ack, output, 1, injection consumed pulse.
REQ-015 The module SHALL have port init_done, output, 1, 1=parity RAM fully initialised.
REQ-016 The module SHALL have port parity_err, output, MXLY, per-layer read parity error, one bit per layer RAM.

Function
REQ-017 The module SHALL hold an internal 2**RAM_ADRB x MXLY parity RAM, one even-parity bit per layer per address.
REQ-018 The FSM SHALL have states IDLE, INIT, RUN; IDLE->INIT unconditionally on the first clock after reset release.
REQ-019 INIT SHALL write 0 to the parity RAM at init_adr, incrementing from 0; INIT->RUN on the clock after writing address 2**RAM_ADRB-1; init_done=1 only in RUN.
REQ-020 When fifo_wen=1 in INIT, the external write SHALL take priority, and init_adr SHALL stall that cycle.
REQ-021 On fifo_wen=1, parity RAM[fifo_wadr][n] SHALL be written with ^fifo_wdata layer n, XOR inject mask bit n.
REQ-022 The inject mask SHALL be inject_ly when inject_req=1 and the FSM is in RUN, else 0.
REQ-023 Injection SHALL be one-shot: the first write with a nonzero-armed inject SHALL produce inject_ack=1 for exactly 1 clock on the following cycle.
REQ-024 inject_req SHALL be ignored while inject_ack=1, so a held request corrupts exactly one write.
REQ-025 A read with fifo_ren=1 at cycle T SHALL read the parity RAM at fifo_radr and register ren_ff.
REQ-026 At T+1, the module SHALL compute parity_calc[n] = ^fifo_rdata layer n and compare it with the stored bit.
REQ-027 parity_err[n] SHALL be registered at T+2 as (calc != stored) AND ren_ff AND init_done; the latency is 2 clocks.
REQ-028 parity_err SHALL be 0 on any cycle whose read slot had fifo_ren=0, and SHALL NOT be latched.
REQ-029 On a simultaneous read and write to the same address, the read SHALL return the old parity (read-first).
REQ-030 Address counters SHALL wrap modulo 2**RAM_ADRB, with no overflow flag.

Reset
REQ-031 global_reset_n=0 SHALL asynchronously force state=IDLE, init_adr=0, init_done=0, parity_err=0, inject_ack=0, and the read pipeline valids=0.
REQ-032 Parity RAM contents are not reset; they SHALL be rewritten by INIT after every reset, including a reset mid-INIT or mid-RUN.

Verification
REQ-033 Release reset with no traffic -> init_done rises exactly 2**RAM_ADRB+1 clocks after release; parity_err stays 0.
REQ-034 In RUN, write adr 5 data all layers 0x01, then read adr 5 with rdata 0x01 -> parity_err=0 two clocks after the read.
REQ-035 Write adr 7 with inject_req=1, inject_ly=6'b000100, then read adr 7 with matching data -> parity_err=6'b000100 at T+2; inject_ack pulses once.
REQ-036 Write adr 9 with layer 3 data 0x03, then read adr 9 with rdata layer 3=0x07 -> parity_err=6'b001000 for exactly 1 clock.
REQ-037 Assert fifo_wen continuously during INIT -> init_done is delayed by the number of write cycles, and external write parity is preserved on readback.
REQ-038 Assert global_reset_n=0 mid-RUN with a read in flight -> parity_err=0 immediately, FSM re-enters INIT, and init_done=0 until INIT completes.
